// File: rtl/mvm_job_driver.sv
// mvm_job_driver: loads an N x N matrix and N-vector from a serial stream, starts a
// matrix-vector multiplier, then streams the result back. Optional timeout: MVM_TIMEOUT_EN.
module mvm_job_driver #(
    parameter int unsigned N       = 3,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*N*WIDTH-1:0] matrix_a,
    output logic [N*WIDTH-1:0]   vector_b,
    output logic                 ena,
    input  logic [N*WIDTH-1:0]   vector_c,
    input  logic                 done,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err
);
    localparam int unsigned NN    = N * N;
    localparam int unsigned CNT_W = $clog2(NN + 1);

    if (N == 0 || WIDTH == 0 || TIMEOUT == 0) begin : g_param_check
        $error("mvm_job_driver: N, WIDTH and TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   armed_q;
    logic [NN*WIDTH-1:0]    matrix_a_q;
    logic [N*WIDTH-1:0]     vector_b_q;
    logic [N*WIDTH-1:0]     result_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   ena_q;
    logic [WIDTH-1:0]       out_data_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic                   in_fire_c;
    logic                   out_fire_c;
    logic [WIDTH-1:0]       next_elem_c;

`ifdef MVM_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
    logic [WCNT_W-1:0]      wcnt_q;
    logic                   err_q;
`endif

    assign in_fire_c  = in_valid && in_ready_q;
    assign out_fire_c = out_valid_q && out_ready;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD_A: if (in_fire_c && cnt_q == CNT_W'(NN - 1)) state_d = S_LOAD_B;
            S_LOAD_B: if (in_fire_c && cnt_q == CNT_W'(N - 1)) state_d = S_START;
            S_START:  state_d = S_WAIT;
            S_WAIT: begin
                if (armed_q && done) begin
                    state_d = S_DRAIN;
                end
`ifdef MVM_TIMEOUT_EN
                else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    state_d = S_LOAD_A;
                end
`endif
            end
            S_DRAIN:  if (out_fire_c && cnt_q == CNT_W'(N - 1)) state_d = S_LOAD_A;
            default:  state_d = S_LOAD_A;
        endcase
    end

    // Result element presented after the current one is accepted
    always_comb begin
        next_elem_c = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(i)) begin
                next_elem_c = result_q[(N - 1 - i) * WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD_A;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            matrix_a_q  <= '0;
            vector_b_q  <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            ena_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
            busy_q     <= (state_d != S_LOAD_A);
            ena_q      <= (state_d == S_START);
            case (state_q)
                S_LOAD_A: begin
                    if (in_fire_c) begin
                        for (int e = 0; e < NN; e++) begin
                            if (cnt_q == CNT_W'(NN - 1 - e)) matrix_a_q[e * WIDTH +: WIDTH] <= in_data;
                        end
                        cnt_q <= (state_d == S_LOAD_B) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                S_LOAD_B: begin
                    if (in_fire_c) begin
                        for (int e = 0; e < N; e++) begin
                            if (cnt_q == CNT_W'(N - 1 - e)) vector_b_q[e * WIDTH +: WIDTH] <= in_data;
                        end
                        cnt_q <= (state_d == S_START) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                S_START: armed_q <= 1'b0;
                // A done left high by an earlier job is ignored until done is seen low
                S_WAIT: begin
                    if (!done) armed_q <= 1'b1;
                    if (state_d == S_DRAIN) begin
                        result_q    <= vector_c;
                        out_valid_q <= 1'b1;
                        out_data_q  <= vector_c[(N - 1) * WIDTH +: WIDTH];
                        out_last_q  <= (N == 1);
                        cnt_q       <= '0;
                        armed_q     <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (out_fire_c) begin
                        if (state_d == S_LOAD_A) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q      <= cnt_q + CNT_W'(1);
                            out_data_q <= next_elem_c;
                            out_last_q <= (cnt_q + CNT_W'(1) == CNT_W'(N - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MVM_TIMEOUT_EN
    // WAIT cycle counter; an expiry abandons the job and latches err until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= (state_q == S_WAIT) ? wcnt_q + WCNT_W'(1) : '0;
            if (state_q == S_WAIT && state_d == S_LOAD_A) err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign ena       = ena_q;
    assign matrix_a  = matrix_a_q;
    assign vector_b  = vector_b_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mvm_job_driver.sv
// Bench for mvm_job_driver: fixed job table, hand-written corner sequences and random
// jobs, with a behavioural multiplier and a plain-arithmetic reference for results.
module tb_mvm_job_driver;
    localparam int unsigned N       = 3;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned NN      = N * N;

    typedef struct packed {
        logic [NN*WIDTH-1:0] a;
        logic [N*WIDTH-1:0]  b;
        logic [N*WIDTH-1:0]  c;
    } job_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [NN*WIDTH-1:0]  matrix_a;
    logic [N*WIDTH-1:0]   vector_b;
    logic                 ena;
    logic [N*WIDTH-1:0]   vector_c;
    logic                 done;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 err;

    logic                 auto_mode;
    logic                 man_done;
    logic [N*WIDTH-1:0]   man_c;
    int                   mult_lat;
    logic                 m_done = 1'b0;
    logic [N*WIDTH-1:0]   m_c = '0;
    int                   m_cnt = 0;
    int                   ena_cnt = 0;
    int                   checks = 0;
    int                   errors = 0;
    logic                 exp_err = 1'b0;
    job_t                 tbl [4];

    always #5 clk = ~clk;

    mvm_job_driver #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .matrix_a(matrix_a), .vector_b(vector_b), .ena(ena),
        .vector_c(vector_c), .done(done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .err(err)
    );

    // Reference: c[r] = sum_k A[r][k]*b[k], wrapped to WIDTH bits; c[0] packed in the MSBs
    function automatic logic [N*WIDTH-1:0] mvm_model(input logic [NN*WIDTH-1:0] a,
                                                     input logic [N*WIDTH-1:0] b);
        logic [N*WIDTH-1:0] c;
        logic signed [WIDTH-1:0] ae, be;
        int acc;
        c = '0;
        for (int r = 0; r < N; r++) begin
            acc = 0;
            for (int k = 0; k < N; k++) begin
                ae = a[(NN - 1 - (r * N + k)) * WIDTH +: WIDTH];
                be = b[(N - 1 - k) * WIDTH +: WIDTH];
                acc += int'(ae) * int'(be);
            end
            c[(N - 1 - r) * WIDTH +: WIDTH] = WIDTH'(acc);
        end
        return c;
    endfunction

    // Behavioural multiplier: drops done on ena, raises it mult_lat+1 cycles later
    always @(posedge clk) begin
        if (ena) begin
            m_done <= 1'b0;
            m_c    <= mvm_model(matrix_a, vector_b);
            m_cnt  <= mult_lat;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end
    end

    always @(posedge clk) if (ena) ena_cnt <= ena_cnt + 1;

    assign done     = auto_mode ? m_done : man_done;
    assign vector_c = auto_mode ? m_c : man_c;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),  128'(1));
        check({tag, "_busy"},      128'(busy),      128'(0));
        check({tag, "_ena"},       128'(ena),       128'(0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_last"},  128'(out_last),  128'(0));
        check({tag, "_out_data"},  128'(out_data),  128'(0));
        check({tag, "_err"},       128'(err),       128'(0));
        check({tag, "_matrix_a"},  128'(matrix_a),  128'(0));
        check({tag, "_vector_b"},  128'(vector_b),  128'(0));
    endtask

    // Called at a negedge; returns at the negedge after the element is accepted
    task automatic push(input logic [WIDTH-1:0] d, input bit gap);
        int g;
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        in_data  = d;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_wait", 128'(in_ready), 128'(1));
        @(negedge clk);
    endtask

    // Loads a job; returns during the first WAIT cycle
    task automatic push_job(input job_t j, input bit gaps);
        logic [WIDTH-1:0] d;
        for (int k = 0; k < NN + N; k++) begin
            if (k < NN) d = j.a[(NN - 1 - k) * WIDTH +: WIDTH];
            else        d = j.b[(N - 1 - (k - NN)) * WIDTH +: WIDTH];
            push(d, gaps && ($urandom_range(0, 3) == 0));
        end
        in_valid = 1'b0;
        check("ena_after_last_elem", 128'(ena),      128'(1));
        check("in_ready_in_start",   128'(in_ready), 128'(0));
        check("busy_in_start",       128'(busy),     128'(1));
        check("matrix_a_layout",     128'(matrix_a), 128'(j.a));
        check("vector_b_layout",     128'(vector_b), 128'(j.b));
        @(negedge clk);
        check("ena_one_cycle",       128'(ena),      128'(0));
    endtask

    // stall: 0 always ready, 1 random ready, 2 ready held low for the first 5 cycles
    task automatic drain_job(input job_t j, input int stall);
        int g, i, cyc;
        logic rdy;
        logic [WIDTH-1:0] ex;
        g = 0;
        while (!out_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("out_valid_rise", 128'(out_valid), 128'(1));
        i = 0;
        cyc = 0;
        while (i < N && cyc < 400) begin
            ex = j.c[(N - 1 - i) * WIDTH +: WIDTH];
            check("out_valid_hold", 128'(out_valid), 128'(1));
            check("out_data",       128'(out_data),  128'(ex));
            check("out_last",       128'(out_last),  128'(i == N - 1));
            check("matrix_a_held",  128'(matrix_a),  128'(j.a));
            check("vector_b_held",  128'(vector_b),  128'(j.b));
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = (cyc >= 5);
            endcase
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) i++;
        end
        out_ready = 1'b0;
        check("drain_count",    128'(i),         128'(N));
        check("out_valid_fall", 128'(out_valid), 128'(0));
        check("in_ready_after", 128'(in_ready),  128'(1));
        check("busy_after",     128'(busy),      128'(0));
        check("err_level",      128'(err),       128'(exp_err));
    endtask

    task automatic run_job(input job_t j, input int stall, input int lat, input bit gaps);
        int e0;
        auto_mode = 1'b1;
        mult_lat  = lat;
        e0 = ena_cnt;
        push_job(j, gaps);
        drain_job(j, stall);
        check("ena_pulses", 128'(ena_cnt - e0), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t j;
        int e0;

        tbl[0] = '{a: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9},
                   b: {8'd1, 8'd2, 8'd3},
                   c: {8'd14, 8'd32, 8'd50}};
        tbl[1] = '{a: {8'd10, 8'hFD, 8'd5, 8'hF8, 8'd12, 8'd0, 8'd7, 8'd1, 8'hFE},
                   b: {8'hFC, 8'd9, 8'd3},
                   c: {8'hCC, 8'h8C, 8'hE7}};
        tbl[2] = '{a: {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1},
                   b: {8'd5, 8'hFA, 8'h7F},
                   c: {8'd5, 8'hFA, 8'h7F}};
        tbl[3] = '{a: {8'h7F, 8'h7F, 8'h7F, 8'd0, 8'd0, 8'd0, 8'hFF, 8'hFF, 8'hFF},
                   b: {8'd1, 8'd1, 8'd1},
                   c: {8'h7D, 8'h00, 8'hFD}};

        auto_mode = 1'b1;
        mult_lat  = 2;
        man_done  = 1'b0;
        man_c     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 4; t++) run_job(tbl[t], 0, 2, 1'b0);

        // Consumer stalls on the first result for five cycles
        run_job(tbl[0], 2, 3, 1'b0);

        // done held high from before: no capture until it has been seen low
        auto_mode = 1'b0;
        man_done  = 1'b1;
        man_c     = tbl[1].c;
        e0 = ena_cnt;
        push_job(tbl[1], 1'b0);
        check("stale_done_wait1", 128'(out_valid), 128'(0));
        @(negedge clk);
        man_done = 1'b0;
        check("stale_done_wait2", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("armed_no_capture", 128'(out_valid), 128'(0));
        man_done = 1'b1;
        @(negedge clk);
        check("capture_latency",  128'(out_valid), 128'(1));
        drain_job(tbl[1], 0);
        check("manual_ena_pulses", 128'(ena_cnt - e0), 128'(1));
        auto_mode = 1'b1;

        // Reset in the middle of WAIT aborts the job; the late done is ignored
        mult_lat = 20;
        push_job(tbl[2], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("wait_reset");
        repeat (30) @(negedge clk);
        check("abort_no_output", 128'(out_valid), 128'(0));
        check("abort_in_ready",  128'(in_ready),  128'(1));
        check("abort_busy",      128'(busy),      128'(0));

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < NN; k++) j.a[k * WIDTH +: WIDTH] = WIDTH'($urandom);
            for (int k = 0; k < N; k++)  j.b[k * WIDTH +: WIDTH] = WIDTH'($urandom);
            j.c = mvm_model(j.a, j.b);
            run_job(j, $urandom_range(0, 1), $urandom_range(1, 6), 1'b1);
        end

`ifdef MVM_TIMEOUT_EN
        auto_mode = 1'b0;
        man_done  = 1'b0;
        push_job(tbl[0], 1'b0);
        repeat (15) @(negedge clk);
        check("timeout_err_pre",  128'(err),  128'(0));
        check("timeout_busy_pre", 128'(busy), 128'(1));
        @(negedge clk);
        check("timeout_err",      128'(err),       128'(1));
        check("timeout_busy",     128'(busy),      128'(0));
        check("timeout_in_ready", 128'(in_ready),  128'(1));
        check("timeout_no_out",   128'(out_valid), 128'(0));
        exp_err = 1'b1;
        run_job(tbl[0], 0, 2, 1'b0);
`else
        check("err_tied_low", 128'(err), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvm_job_driver.md
MVM_JOB_DRIVER -- requirements
Module: mvm_job_driver

Interface
REQ-001 Parameter N, default 3, matrix dimension.
REQ-002 Parameter WIDTH, default 8, signed element width.
REQ-003 Parameter TIMEOUT, default 64, maximum WAIT cycles; used only with MVM_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_data  input  WIDTH  serial element: N*N matrix elements row-major, then N vector elements.
REQ-007 in_valid  input  1  / in_ready  output  1  input handshake; transfer when both are high.
REQ-008 matrix_a  output  N*N*WIDTH  flattened matrix to the multiplier.
REQ-009 vector_b  output  N*WIDTH  flattened vector to the multiplier.
REQ-010 ena  output  1  one-cycle start pulse to the multiplier.
REQ-011 vector_c  input  N*WIDTH  multiplier result.
REQ-012 done  input  1  multiplier completion flag.
REQ-013 out_data  output  WIDTH  / out_valid  output  1  / out_ready  input  1  / out_last  output  1  result stream.
REQ-014 busy  output  1  high in every state except LOAD_A.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 FSM states: LOAD_A, LOAD_B, START, WAIT, DRAIN; outputs registered.
REQ-017 in_ready SHALL be 1 only in LOAD_A and LOAD_B.
REQ-018 Input element k (0-based) in LOAD_A SHALL be written to matrix_a[(N*N-1-k)*WIDTH +: WIDTH] (MSB-first). After k=N*N-1, go to LOAD_B.
REQ-019 Vector element j in LOAD_B SHALL be written to vector_b[(N-1-j)*WIDTH +: WIDTH]. After j=N-1, go to START.
REQ-020 In START, ena SHALL be 1 for exactly one cycle; next state WAIT.
REQ-021 matrix_a and vector_b SHALL hold their values from START through the end of DRAIN.
REQ-022 WAIT arms when done=0 is sampled. In an armed WAIT, the first done=1 SHALL capture vector_c into the result register and go to DRAIN. A done held high from a previous job SHALL be ignored.
REQ-023 In DRAIN, out_valid=1 and out_data=result[(N-1-i)*WIDTH +: WIDTH] for index i=0..N-1. out_last=1 when i=N-1.
REQ-024 i SHALL advance only on out_valid&&out_ready. out_data SHALL stay stable while stalled. After the last transfer, go to LOAD_A with out_valid=0 on the next cycle.
REQ-025 Results SHALL pass through unmodified; no width change or saturation.
REQ-026 Latency: ena SHALL assert the cycle after the final vector-element transfer. out_valid SHALL assert the cycle after done is captured.

Reset
REQ-027 On rst=1 at a clock edge: state=LOAD_A, all counters=0, matrix_a=vector_b=result=0, ena=0, out_valid=0, out_last=0, err=0.
REQ-028 Reset in any state, including WAIT or DRAIN, SHALL abort the job. A later done SHALL then be treated as stale per REQ-022.

Configuration
REQ-029 Macro MVM_TIMEOUT_EN defined: a WAIT cycle counter runs. If done is not captured after TIMEOUT WAIT cycles, err:=1 (sticky until rst) and state:=LOAD_A; no output is produced.
REQ-030 Macro MVM_TIMEOUT_EN undefined: WAIT waits indefinitely; err is tied 0 and no counter is synthesised.

Verification
REQ-031 Matrix [[1,2,3],[4,5,6],[7,8,9]], vector [1,2,3], behavioural multiplier -> ena pulses once; out stream 14, 32, 50; out_last on 50.
REQ-032 Matrix [[10,-3,5],[-8,12,0],[7,1,-2]], vector [-4,9,3] -> out 8'hCC, 8'h8C, 8'hE7.
REQ-033 Same job with out_ready=0 for 5 cycles on the first result -> out_valid held, out_data stable at 14, no element lost or duplicated.
REQ-034 done held at 1 through START and the first WAIT cycle, then 0, then 1 -> capture occurs only after the 0->1 transition.
REQ-035 rst=1 for one cycle mid-WAIT -> next cycle state LOAD_A, in_ready=1, busy=0, all outputs at reset values.
REQ-036 MVM_TIMEOUT_EN defined, TIMEOUT=16, done never asserted -> err=1 after 16 WAIT cycles, return to LOAD_A; next job completes normally with err still 1.
